// File: rtl/truth_table_prober.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_prober
//  Description : Sweeps an N-input gate through every input row, waits a
//                settle interval per row, samples the response and assembles
//                the hex truth-table code (row 0 lands in the MSB).
//                Optional build macro: STABILITY_CHECK_EN (adds a per-row
//                early capture and a sticky "unstable" flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_prober #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int TT_W          = 2**N_IN   // derived; leave at default
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_code,
    output logic            valid,
    output logic            unstable
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_reload = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN:0]    c_last_row   = (N_IN+1)'(TT_W - 1);

    logic [1:0]       r_state;
    logic [N_IN:0]    r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [TT_W-1:0]  r_shadow;
    logic [TT_W-1:0]  r_tt_code;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;

    logic             w_sample;
    logic             w_last_row;
    logic [TT_W-1:0]  w_shadow_next;

    // Sampling happens on the edge where the settle counter has run out
    assign w_sample      = (r_state == S_SETTLE) && (r_cnt == '0);
    assign w_last_row    = (r_row == c_last_row);
    assign w_shadow_next = {r_shadow[TT_W-2:0], dut_out};

    // Gate inputs are forced low while idle; in DONE the last row is held
    assign dut_in  = (r_state == S_IDLE) ? '0 : r_row[N_IN-1:0];
    assign busy    = r_busy;
    assign done    = r_done;
    assign tt_code = r_tt_code;
    assign valid   = r_valid;

    // Main sweep FSM: row stepping, settle countdown and code assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_tt_code <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_SETTLE;
                        r_row    <= '0;
                        r_cnt    <= c_cnt_reload;
                        r_busy   <= 1'b1;
                        r_shadow <= '0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_shadow <= w_shadow_next;
                        if (w_last_row) begin
                            // Code is published only on a complete sweep
                            r_state   <= S_DONE;
                            r_tt_code <= w_shadow_next;
                            r_valid   <= 1'b1;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_row <= r_row + (N_IN+1)'(1);
                            r_cnt <= c_cnt_reload;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STABILITY_CHECK_EN
    logic r_early;
    logic r_flag;
    logic r_unstable;
    logic w_early_cap;
    logic w_early_val;
    logic w_mismatch;

    // With a one-cycle settle the row's only edge is the sampling edge, so
    // the early capture degenerates to the sample itself.
    assign w_early_cap = (SETTLE_CYCLES > 1) && (r_state == S_SETTLE) &&
                         (r_cnt == CNT_W'(1));
    assign w_early_val = (SETTLE_CYCLES > 1) ? r_early : dut_out;
    assign w_mismatch  = w_sample && (w_early_val != dut_out);
    assign unstable    = r_unstable;

    // Early capture and sticky per-sweep instability flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_early    <= 1'b0;
            r_flag     <= 1'b0;
            r_unstable <= 1'b0;
        end else begin
            if (w_early_cap) begin
                r_early <= dut_out;
            end
            if ((r_state == S_IDLE) && start) begin
                r_flag <= 1'b0;
            end else if (w_mismatch) begin
                r_flag <= 1'b1;
            end
            if (w_sample && w_last_row) begin
                r_unstable <= r_flag | w_mismatch;
            end
        end
    end
`else
    assign unstable = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_prober.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_prober
//  Description : Directed self-checking bench for truth_table_prober, using a
//                default instance (3 inputs, 4-cycle settle) and a small
//                instance (2 inputs, 1-cycle settle) driven by gate models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_prober;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy, done, valid, unstable;
    logic [7:0] tt_code;

    logic       start2;
    logic [1:0] dut2_in;
    logic       dut2_out;
    logic       busy2, done2, valid2, unstable2;
    logic [3:0] tt_code2;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mode     = 0;
    logic       tog      = 1'b0;
    logic [7:0] tt_ab    = 8'hAB;

`ifdef STABILITY_CHECK_EN
    localparam logic c_stab = 1'b1;
`else
    localparam logic c_stab = 1'b0;
`endif

    truth_table_prober dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .tt_code  (tt_code),
        .valid    (valid),
        .unstable (unstable)
    );

    truth_table_prober #(.N_IN(2), .SETTLE_CYCLES(1)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .dut_in   (dut2_in),
        .dut_out  (dut2_out),
        .busy     (busy2),
        .done     (done2),
        .tt_code  (tt_code2),
        .valid    (valid2),
        .unstable (unstable2)
    );

    always #5 clk = ~clk;

    // Glitch source toggled away from the active edge
    always @(negedge clk) tog = ~tog;

    // Gate models: 0 = 8'hAB function, 1 = in1, 2 = const 1, 3 = AB with row 3 toggling
    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = tt_ab[~dut_in];
            1:       dut_out = dut_in[2];
            2:       dut_out = 1'b1;
            default: dut_out = (dut_in == 3'd3) ? tog : tt_ab[~dut_in];
        endcase
    end

    assign dut2_out = &dut2_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sweep on the default instance; k counts edges after the accepting edge
    task automatic sweep(input int pulse_k, input int chk_k, input logic [7:0] chk_tt,
                         output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_at_start", busy, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            if (k == pulse_k) start = 1'b1;
            step();
            start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (k == 5) check("row1_drive", dut_in, 3'd1);
            if (k == chk_k) check("tt_hold", tt_code, chk_tt);
        end
    endtask

    initial begin
        int fd, nd;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) step();
        check("rst_dut_in", dut_in, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tt", tt_code, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_unstable", unstable, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // AB gate
        mode = 0;
        sweep(0, 0, 8'h00, fd, nd);
        check("ab_done_edge", fd, 32);
        check("ab_done_count", nd, 1);
        check("ab_tt", tt_code, 8'hAB);
        check("ab_valid", valid, 1'b1);
        check("ab_busy", busy, 1'b0);

        // in1 passthrough then constant 1, code holds until second done
        mode = 1;
        sweep(0, 0, 8'h00, fd, nd);
        check("in1_tt", tt_code, 8'h0F);
        mode = 2;
        sweep(0, 20, 8'h0F, fd, nd);
        check("one_tt", tt_code, 8'hFF);
        check("one_done_edge", fd, 32);

        // start re-pulsed mid-sweep is ignored
        mode = 0;
        sweep(10, 0, 8'h00, fd, nd);
        check("ign_done_edge", fd, 32);
        check("ign_done_count", nd, 1);
        check("ign_tt", tt_code, 8'hAB);

        // start held high: next sweep accepted two edges after the done edge
        start = 1'b1;
        step();
        fd = -1;
        for (int k = 1; k <= 34; k++) begin
            step();
            if (done && fd < 0) fd = k;
            if (k == 33) check("held_idle_busy", busy, 1'b0);
            if (k == 34) check("held_restart_busy", busy, 1'b1);
        end
        start = 1'b0;
        check("held_done_edge", fd, 32);
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done) nd++;
        end
        check("held_second_done", nd, 1);

        // reset mid-sweep after a completed AB run
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        rst_n = 1'b0;
        #1;
        check("abort_tt", tt_code, 8'h00);
        check("abort_valid", valid, 1'b0);
        check("abort_dut_in", dut_in, 3'd0);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_valid_low", valid, 1'b0);

        // small instance: 2-input AND, one-cycle settle
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        fd = -1;
        nd = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (done2) begin
                nd++;
                if (fd < 0) fd = k;
            end
        end
        check("and_done_edge", fd, 4);
        check("and_done_count", nd, 1);
        check("and_tt", tt_code2, 4'h1);
        check("and_valid", valid2, 1'b1);

        // glitching row 3, then a clean rerun
        mode = 3;
        sweep(0, 0, 8'h00, fd, nd);
        check("glitch_unstable", unstable, c_stab);
        mode = 0;
        sweep(0, 0, 8'h00, fd, nd);
        check("clean_unstable", unstable, 1'b0);
        check("clean_tt", tt_code, 8'hAB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/truth_table_prober.md
Name: truth_table_prober

Overview:
Sequential characterizer that is the reader side of our N-input truth-table gate modules. It sweeps the gate-under-test through every input combination, waits a settle interval, samples the response and assembles the hex truth-table code used to name the gate (e.g. 8'hAB for 3 inputs). It sits in the bench/characterization harness between the gate instance and the reporting logic.

Parameters:
N_IN, 3, number of gate inputs driven; legal range 1..5.
SETTLE_CYCLES, 4, clock cycles each input row is held before sampling; legal minimum 1.
TT_W, 2**N_IN, derived width of the truth-table code; not to be overridden.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; sampled only in IDLE
dut_in  output  N_IN  drive to gate inputs; MSB = in1, LSB = in{N_IN}
dut_out  input  1  gate response
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when tt_code is updated
tt_code  output  TT_W  last completed truth-table code
valid  output  1  high once any sweep has completed
unstable  output  1  stability flag; see Optional Feature

Behaviour:
- Reset: async assert clears everything. state=IDLE, dut_in=0, busy=0, done=0, tt_code=0, valid=0, unstable=0, row counter=0, settle counter=0, shadow shift register=0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE: dut_in=0. On an edge with start=1, go to SETTLE, set row=0, settle counter=SETTLE_CYCLES-1, busy=1, clear shadow.
- SETTLE: dut_in=row. Decrement the settle counter each edge. On the edge where the counter is 0:
  - shift dut_out into shadow, so row k lands at bit TT_W-1-k (row 0 becomes the MSB).
  - if row==TT_W-1, go to DONE.
  - otherwise increment row and reload the counter.
- DONE, one cycle: tt_code=shadow, valid=1, done=1, busy=0, dut_in holds the last row. The next edge returns to IDLE.
- Timing: take E0 as the edge that accepts start. Row k is sampled at edge E0+SETTLE_CYCLES*(k+1). The last sample is at E0+SETTLE_CYCLES*TT_W, and done is high for the following cycle. Defaults give samples at E0+4..E0+32 and done between E32 and E33.
- start while busy or in DONE: ignored, no queuing. If start is held high continuously, the next sweep begins on the edge after DONE returns to IDLE.
- tt_code changes only in DONE. A partial sweep never alters it.
- Reset mid-sweep: immediate abort, all state as at reset, and valid drops to 0.
- Row counter width: N_IN+1 bits. It does not wrap because termination uses the row==TT_W-1 compare.
- dut_out is sampled raw. Callers must ensure SETTLE_CYCLES covers the gate's propagation delay.

Optional Feature:
STABILITY_CHECK_EN
- Defined: dut_out is also captured one edge before the sampling edge (at counter==1). When SETTLE_CYCLES==1, the first edge of the row is used instead. If the two captures differ on any row, a sticky flag is set. In DONE, unstable=flag. The flag clears when a new sweep starts.
- Undefined: unstable is tied to 0 and no extra flops are built.

Test Plan:
1. Gate model of 8'hAB function (out=0 only for rows 001,011,101) on dut_in; pulse start -> after 33 cycles done pulses once, tt_code=8'hAB, valid=1, busy low.
2. dut_out=in1 (dut_in[2]) -> tt_code=8'h0F. Then dut_out tied 1 on a second run -> tt_code=8'hFF. tt_code holds 8'h0F until the second done.
3. start pulsed again at E0+10 during a sweep -> ignored; exactly one done at E0+33 for that sweep. With start held high, the second sweep's E0 lands 2 edges after the first done edge.
4. rst_n asserted at E0+15 of a sweep that follows a completed 8'hAB run -> tt_code=0, valid=0, dut_in=0, busy=0 immediately. No done pulse.
5. SETTLE_CYCLES=1, N_IN=2, dut_out=AND of inputs -> tt_code=4'h1, done 5 cycles after the start edge.
6. With STABILITY_CHECK_EN defined, dut_out toggles during the settle of row 3 only -> unstable=1 at done. A clean rerun -> unstable=0. Without the macro, unstable stays 0.
